// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and encodings for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

  localparam int BRANCH_WIDTH = 5;
  localparam int REG_W        = 5;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef enum logic [1:0] {
    PHC_RUN      = 2'd0,
    PHC_MEM_WAIT = 2'd1,
    PHC_HALT     = 2'd2
  } phc_state_e;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - register index compare; r0 is hardwired zero so it never matches
module hazard_match
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             dst_en,
  input  logic [REG_W-1:0] dst,
  input  logic             src_en,
  input  logic [REG_W-1:0] src,
  output logic             hit
);

  assign hit = dst_en & src_en & (dst != '0) & (dst == src);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward sequencer with dmem wait FSM and perf counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_rf_rea,
  input  logic [REG_W-1:0]        id_rs,
  input  logic                    id_rf_reb,
  input  logic [REG_W-1:0]        id_rt,
  input  logic [BRANCH_WIDTH-1:0] id_branch_type,
  input  logic                    id_branch_take,
  input  logic                    ex_rf_we,
  input  logic                    ex_mem_re,
  input  logic [REG_W-1:0]        ex_rf_dst,
  input  logic                    mem_rf_we,
  input  logic                    mem_mem_re,
  input  logic [REG_W-1:0]        mem_rf_dst,
  input  logic                    dmem_req,
  input  logic                    dmem_ack,
  input  logic                    imem_ack,
  output logic                    pc_we,
  output logic                    if_id_we,
  output logic                    id_ex_we,
  output logic                    ex_mem_we,
  output logic                    mem_wb_we,
  output logic                    if_id_flush,
  output logic                    id_ex_flush,
  output logic [1:0]              fwd_a,
  output logic [1:0]              fwd_b,
  output logic                    mem_err,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  localparam int TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  phc_state_e       state;
  logic [TMO_W-1:0] tmo;
  logic [REG_W-1:0] idex_rs, idex_rt;
  logic             wb_we;
  logic [REG_W-1:0] wb_dst;

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic fa_mem, fa_wb, fb_mem, fb_wb;
  logic freeze, load_use, branch_data, stall, is_branch;

  hazard_match u_ex_rs  (.dst_en(ex_rf_we),              .dst(ex_rf_dst),  .src_en(id_rf_rea), .src(id_rs),   .hit(ex_hit_rs));
  hazard_match u_ex_rt  (.dst_en(ex_rf_we),              .dst(ex_rf_dst),  .src_en(id_rf_reb), .src(id_rt),   .hit(ex_hit_rt));
  hazard_match u_mem_rs (.dst_en(mem_mem_re & mem_rf_we), .dst(mem_rf_dst), .src_en(id_rf_rea), .src(id_rs),   .hit(mem_hit_rs));
  hazard_match u_mem_rt (.dst_en(mem_mem_re & mem_rf_we), .dst(mem_rf_dst), .src_en(id_rf_reb), .src(id_rt),   .hit(mem_hit_rt));
  hazard_match u_fa_mem (.dst_en(mem_rf_we),             .dst(mem_rf_dst), .src_en(1'b1),      .src(idex_rs), .hit(fa_mem));
  hazard_match u_fa_wb  (.dst_en(wb_we),                 .dst(wb_dst),     .src_en(1'b1),      .src(idex_rs), .hit(fa_wb));
  hazard_match u_fb_mem (.dst_en(mem_rf_we),             .dst(mem_rf_dst), .src_en(1'b1),      .src(idex_rt), .hit(fb_mem));
  hazard_match u_fb_wb  (.dst_en(wb_we),                 .dst(wb_dst),     .src_en(1'b1),      .src(idex_rt), .hit(fb_wb));

  always_comb begin
    is_branch   = |id_branch_type;
    freeze      = ((state == PHC_RUN) & dmem_req & ~dmem_ack)
                | ((state == PHC_MEM_WAIT) & ~dmem_ack)
                | (state == PHC_HALT);
    load_use    = ex_mem_re & (ex_hit_rs | ex_hit_rt);
    branch_data = is_branch & (ex_hit_rs | ex_hit_rt | mem_hit_rs | mem_hit_rt);
    stall       = load_use | branch_data;

    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    id_ex_we    = 1'b1;
    ex_mem_we   = 1'b1;
    mem_wb_we   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (freeze) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (stall) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX; older stages drain.
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (is_branch & id_branch_take) begin
      if_id_flush = 1'b1;
    end else if (~imem_ack) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  assign fwd_a = fa_mem ? FWD_EXMEM : (fa_wb ? FWD_MEMWB : FWD_RF);
  assign fwd_b = fb_mem ? FWD_EXMEM : (fb_wb ? FWD_MEMWB : FWD_RF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PHC_RUN;
      tmo     <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        PHC_RUN: begin
          tmo <= '0;
          if (dmem_req & ~dmem_ack) state <= PHC_MEM_WAIT;
        end
        PHC_MEM_WAIT: begin
          // An ack on the final timeout cycle still completes the access.
          if (dmem_ack) begin
            state <= PHC_RUN;
            tmo   <= '0;
          end else if (tmo == TMO_LAST) begin
            state   <= PHC_HALT;
            mem_err <= 1'b1;
            tmo     <= '0;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        PHC_HALT: state <= PHC_HALT;
        default:  state <= PHC_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != PHC_HALT) begin
      if (~pc_we)                     stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush | id_ex_flush)  flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Shadow of the ID/EX operand indices and the MEM/WB destination for forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_rs <= '0;
      idex_rt <= '0;
      wb_we   <= 1'b0;
      wb_dst  <= '0;
    end else begin
      if (id_ex_flush) begin
        idex_rs <= '0;
        idex_rt <= '0;
      end else if (id_ex_we) begin
        idex_rs <= id_rs;
        idex_rt <= id_rt;
      end
      if (mem_wb_we) begin
        wb_we  <= mem_rf_we;
        wb_dst <= mem_rf_dst;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_rf_rea, id_rf_reb, id_branch_take;
  logic [4:0]  id_rs, id_rt, id_branch_type;
  logic        ex_rf_we, ex_mem_re, mem_rf_we, mem_mem_re;
  logic [4:0]  ex_rf_dst, mem_rf_dst;
  logic        dmem_req, dmem_ack, imem_ack;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  int checks;
  int failures;

  // {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush}
  localparam logic [6:0] RUNV   = 7'b1111100;
  localparam logic [6:0] STALL  = 7'b0011101;
  localparam logic [6:0] FREEZE = 7'b0000000;
  localparam logic [6:0] REDIR  = 7'b1111110;
  localparam logic [6:0] FMISS  = 7'b0111110;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rf_rea(id_rf_rea), .id_rs(id_rs), .id_rf_reb(id_rf_reb), .id_rt(id_rt),
    .id_branch_type(id_branch_type), .id_branch_take(id_branch_take),
    .ex_rf_we(ex_rf_we), .ex_mem_re(ex_mem_re), .ex_rf_dst(ex_rf_dst),
    .mem_rf_we(mem_rf_we), .mem_mem_re(mem_mem_re), .mem_rf_dst(mem_rf_dst),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .imem_ack(imem_ack),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rf_rea = 0; id_rs = 0; id_rf_reb = 0; id_rt = 0;
    id_branch_type = 0; id_branch_take = 0;
    ex_rf_we = 0; ex_mem_re = 0; ex_rf_dst = 0;
    mem_rf_we = 0; mem_mem_re = 0; mem_rf_dst = 0;
    dmem_req = 0; dmem_ack = 0; imem_ack = 1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_ctl", 32'(ctl()), 32'(RUNV));
    chk("rst_fwd_a", 32'(fwd_a), 0);
    chk("rst_fwd_b", 32'(fwd_b), 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // lw $2 in EX, add $3,$2,$4 in ID
    nxt(); ex_rf_we = 1; ex_mem_re = 1; ex_rf_dst = 2; id_rf_rea = 1; id_rs = 2; id_rf_reb = 1; id_rt = 4;
    @(negedge clk); chk("lu_ctl", 32'(ctl()), 32'(STALL));
    nxt(); mem_rf_we = 1; mem_mem_re = 1; mem_rf_dst = 2; id_rf_rea = 1; id_rs = 2; id_rf_reb = 1; id_rt = 4;
    @(negedge clk);
    chk("lu_resume_ctl", 32'(ctl()), 32'(RUNV));
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_flush_cnt", flush_cnt, 1);
    nxt(); ex_rf_we = 1; ex_rf_dst = 3;
    @(negedge clk);
    chk("lu_fwd_a_memwb", 32'(fwd_a), 2);
    chk("lu_fwd_b_rf", 32'(fwd_b), 0);

    // EX/MEM forward wins over MEM/WB for the same register
    nxt(); id_rf_rea = 1; id_rs = 7; id_rf_reb = 1; id_rt = 5; ex_rf_we = 1; ex_rf_dst = 7; mem_rf_we = 1; mem_rf_dst = 7;
    @(negedge clk); chk("alu_chain_ctl", 32'(ctl()), 32'(RUNV));
    nxt(); mem_rf_we = 1; mem_rf_dst = 7;
    @(negedge clk);
    chk("fwd_a_exmem_prio", 32'(fwd_a), 1);
    chk("fwd_b_nomatch", 32'(fwd_b), 0);

    // add $2 then beq $2,$0 (taken): one stall, then redirect
    nxt(); ex_rf_we = 1; ex_rf_dst = 2; id_branch_type = 1; id_branch_take = 1; id_rf_rea = 1; id_rs = 2; id_rf_reb = 1; id_rt = 0;
    @(negedge clk); chk("br_alu_stall", 32'(ctl()), 32'(STALL));
    nxt(); mem_rf_we = 1; mem_rf_dst = 2; id_branch_type = 1; id_branch_take = 1; id_rf_rea = 1; id_rs = 2; id_rf_reb = 1; id_rt = 0;
    @(negedge clk); chk("br_redirect", 32'(ctl()), 32'(REDIR));

    // lw $2 then beq $2 (not taken): two stalls
    nxt(); ex_rf_we = 1; ex_mem_re = 1; ex_rf_dst = 2; id_branch_type = 1; id_rf_rea = 1; id_rs = 2;
    @(negedge clk); chk("br_ld_stall1", 32'(ctl()), 32'(STALL));
    nxt(); mem_rf_we = 1; mem_mem_re = 1; mem_rf_dst = 2; id_branch_type = 1; id_rf_rea = 1; id_rs = 2;
    @(negedge clk); chk("br_ld_stall2", 32'(ctl()), 32'(STALL));
    nxt(); id_branch_type = 1; id_rf_rea = 1; id_rs = 2;
    @(negedge clk);
    chk("br_ld_go", 32'(ctl()), 32'(RUNV));
    chk("br_stall_cnt", stall_cnt, 4);
    chk("br_flush_cnt", flush_cnt, 5);

    // r0 destination never matches
    nxt(); ex_rf_we = 1; ex_mem_re = 1; ex_rf_dst = 0; mem_rf_we = 1; mem_rf_dst = 0; id_rf_rea = 1; id_rs = 0; id_rf_reb = 1; id_rt = 0;
    @(negedge clk); chk("r0_no_stall", 32'(ctl()), 32'(RUNV));
    nxt(); mem_rf_we = 1; mem_rf_dst = 0;
    @(negedge clk);
    chk("r0_fwd_a", 32'(fwd_a), 0);
    chk("r0_fwd_b", 32'(fwd_b), 0);

    // fetch miss
    nxt(); imem_ack = 0;
    @(negedge clk); chk("fetch_miss", 32'(ctl()), 32'(FMISS));

    // dmem wait: 5 frozen cycles (freeze outranks a pending load-use), ack resumes
    nxt(); dmem_req = 1; ex_rf_we = 1; ex_mem_re = 1; ex_rf_dst = 2; id_rf_rea = 1; id_rs = 2;
    @(negedge clk); chk("dm_freeze_run", 32'(ctl()), 32'(FREEZE));
    for (int i = 0; i < 4; i++) begin
      nxt(); dmem_req = 1; ex_rf_we = 1; ex_mem_re = 1; ex_rf_dst = 2; id_rf_rea = 1; id_rs = 2;
      @(negedge clk); chk("dm_freeze_wait", 32'(ctl()), 32'(FREEZE));
    end
    nxt(); dmem_req = 1; dmem_ack = 1;
    @(negedge clk); chk("dm_ack_ctl", 32'(ctl()), 32'(RUNV));
    nxt();
    @(negedge clk);
    chk("dm_back_run", 32'(ctl()), 32'(RUNV));
    chk("dm_stall_cnt", stall_cnt, 10);
    chk("dm_flush_cnt", flush_cnt, 6);

    // never acked: 1 RUN + 8 MEM_WAIT cycles, then HALT
    nxt(); dmem_req = 1;
    @(negedge clk); chk("to_freeze_run", 32'(ctl()), 32'(FREEZE));
    for (int i = 0; i < 8; i++) begin
      nxt(); dmem_req = 1;
      @(negedge clk);
      chk("to_freeze_wait", 32'(ctl()), 32'(FREEZE));
      chk("to_no_err_yet", 32'(mem_err), 0);
    end
    nxt(); imem_ack = 0;
    @(negedge clk);
    chk("halt_ctl", 32'(ctl()), 32'(FREEZE));
    chk("halt_mem_err", 32'(mem_err), 1);
    chk("halt_stall_cnt", stall_cnt, 19);
    nxt(); dmem_req = 1; dmem_ack = 1;
    @(negedge clk);
    chk("halt_sticky_ctl", 32'(ctl()), 32'(FREEZE));
    chk("halt_stall_hold", stall_cnt, 19);
    chk("halt_flush_hold", flush_cnt, 6);

    // reset leaves HALT
    nxt(); rst_n = 1'b0;
    #1;
    chk("rst2_ctl", 32'(ctl()), 32'(RUNV));
    chk("rst2_mem_err", 32'(mem_err), 0);
    chk("rst2_stall_cnt", stall_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ack on the final timeout cycle wins
    nxt(); dmem_req = 1;
    @(negedge clk); chk("tk_freeze_run", 32'(ctl()), 32'(FREEZE));
    for (int i = 0; i < 7; i++) begin
      nxt(); dmem_req = 1;
      @(negedge clk); chk("tk_freeze_wait", 32'(ctl()), 32'(FREEZE));
    end
    nxt(); dmem_req = 1; dmem_ack = 1;
    @(negedge clk); chk("tk_ack_ctl", 32'(ctl()), 32'(RUNV));
    nxt();
    @(negedge clk);
    chk("tk_run_ctl", 32'(ctl()), 32'(RUNV));
    chk("tk_no_err", 32'(mem_err), 0);
    chk("tk_stall_cnt", stall_cnt, 8);

    // asynchronous reset in the middle of MEM_WAIT
    nxt(); dmem_req = 1;
    @(negedge clk);
    nxt(); dmem_req = 1;
    @(negedge clk); chk("mr_in_wait", 32'(ctl()), 32'(FREEZE));
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b0;
    #1;
    chk("mr_ctl", 32'(ctl()), 32'(RUNV));
    chk("mr_stall_cnt", stall_cnt, 0);
    chk("mr_flush_cnt", flush_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nxt();
    @(negedge clk); chk("mr_run_after", 32'(ctl()), 32'(RUNV));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
